// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one fifo between NREQ writers and one reader.
// Optional macro FIFO_ARB_RD_PRIO_EN: reads always win over writes in IDLE.
module fifo_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]             gnt,
    input  logic                        rd_req,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            fifo_data_in,
    output logic                        fifo_write,
    output logic                        fifo_read,
    input  logic [WIDTH-1:0]            fifo_data_out,
    input  logic                        fifo_full,
    input  logic                        fifo_empty
);

    localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_DONE = 2'd3
    } state_e;

    // Handshake: a requester holds req/req_data until it sees gnt (the write
    // cycle); req still high in the following IDLE counts as a new item.
    // rd_req is a level; each item read yields exactly one rd_valid strobe.

    state_e              state_q, state_d;
    logic [SELW-1:0]     sel_q, sel_d;
    logic [SELW-1:0]     last_q, last_d;
    logic                prio_wr_q, prio_wr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                fifo_write_q, fifo_write_d;
    logic                fifo_read_q, fifo_read_d;
    logic [WIDTH-1:0]    fifo_data_in_q, fifo_data_in_d;
    logic                rd_valid_q, rd_valid_d;

    logic                wr_cand;
    logic                rd_cand;
    logic                go_wr;
    logic                go_rd;
    logic [SELW-1:0]     rr_pick;
    logic                rr_found;
    int                  rr_idx;

    // Search starts just after the last winner and wraps modulo NREQ.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(last_q) + k) % NREQ;
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = SELW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_d         = last_q;
        prio_wr_d      = prio_wr_q;
        gnt_d          = '0;
        fifo_write_d   = 1'b0;
        fifo_read_d    = 1'b0;
        fifo_data_in_d = '0;
        rd_valid_d     = 1'b0;
        wr_cand        = (|req) && !fifo_full;
        rd_cand        = rd_req && !fifo_empty;
        go_wr          = 1'b0;
        go_rd          = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_cand && rd_cand) begin
`ifdef FIFO_ARB_RD_PRIO_EN
                    go_rd = 1'b1;
`else
                    go_wr     = prio_wr_q;
                    go_rd     = !prio_wr_q;
                    prio_wr_d = !prio_wr_q;
`endif
                end else begin
                    go_wr = wr_cand;
                    go_rd = rd_cand;
                end

                if (go_wr) begin
                    state_d            = WR;
                    sel_d              = rr_pick;
                    last_d             = rr_pick;
                    gnt_d[rr_pick]     = 1'b1;
                    fifo_write_d       = 1'b1;
                    fifo_data_in_d     = req_data[rr_pick];
                end else if (go_rd) begin
                    state_d     = RD;
                    fifo_read_d = 1'b1;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                // fifo_data_out becomes valid in the cycle after fifo_read.
                state_d    = RD_DONE;
                rd_valid_d = 1'b1;
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            last_q         <= SELW'(NREQ - 1);
            prio_wr_q      <= 1'b1;
            gnt_q          <= '0;
            fifo_write_q   <= 1'b0;
            fifo_read_q    <= 1'b0;
            fifo_data_in_q <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            last_q         <= last_d;
            prio_wr_q      <= prio_wr_d;
            gnt_q          <= gnt_d;
            fifo_write_q   <= fifo_write_d;
            fifo_read_q    <= fifo_read_d;
            fifo_data_in_q <= fifo_data_in_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    assign gnt          = gnt_q;
    assign fifo_write   = fifo_write_q;
    assign fifo_read    = fifo_read_q;
    assign fifo_data_in = fifo_data_in_q;
    assign rd_valid     = rd_valid_q;
    // The fifo output register is only meaningful during RD_DONE.
    assign rd_data      = (state_q == RD_DONE) ? fifo_data_out : '0;

    a_wr_rd_excl: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_write && fifo_read));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(gnt));
    a_gnt_in_wr: assert property (@(posedge clk) disable iff (!rst)
        (state_q == WR) |-> (gnt[sel_q] && fifo_write));

endmodule
